// File: rtl/zap_uart_tx.sv
// zap_uart_tx: 8N1 UART transmitter fed by a small byte FIFO; define ZAP_UART_TX_PARITY_EN to add an even parity bit
module zap_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic [7:0]                       i_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic                             o_tx,
  output logic                             o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(CLKS_PER_BIT);
`ifdef ZAP_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par, par_d;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift, shift_d;
  logic push, pop, last, tx_d;
  assign o_ready = o_fifo_count != CW'(FIFO_DEPTH);
  assign o_busy = state != IDLE || o_fifo_count != '0;
  assign push = i_valid && o_ready;
  assign last = cnt == TW'(CLKS_PER_BIT - 1);
  assign pop = (state == IDLE || (state == STOP && last)) && o_fifo_count != '0;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:   state_d = pop ? START : IDLE;
      START:  state_d = last ? DATA : START;
`ifdef ZAP_UART_TX_PARITY_EN
      DATA:   state_d = (last && bit_cnt == 3'd7) ? PARITY : DATA;
      PARITY: state_d = last ? STOP : PARITY;
`else
      DATA:   state_d = (last && bit_cnt == 3'd7) ? STOP : DATA;
`endif
      STOP:   state_d = last ? (pop ? START : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
  end
  // o_tx is registered from the next state so the line never glitches
  always_comb begin
    shift_d = pop ? mem[rd_ptr] : (state == DATA && last) ? shift >> 1 : shift;
`ifdef ZAP_UART_TX_PARITY_EN
    par_d = pop ? ^mem[rd_ptr] : par;
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
`else
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`endif
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      o_tx <= 1'b1;
      cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_fifo_count <= '0;
`ifdef ZAP_UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      o_tx <= tx_d;
      cnt <= (state == IDLE || last) ? '0 : cnt + 1'b1;
      if (state == DATA && last) bit_cnt <= bit_cnt + 1'b1;
      shift <= shift_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      o_fifo_count <= o_fifo_count + CW'(push) - CW'(pop);
`ifdef ZAP_UART_TX_PARITY_EN
      par <= par_d;
`endif
    end
  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= i_data;
endmodule

// File: tb/tb_zap_uart_tx.sv
// tb_zap_uart_tx: randomized and directed checks of zap_uart_tx against a frame-level model and a serial decoder
module tb_zap_uart_tx;
  localparam int CPB = 16, DEPTH = 4, CPB_B = 2;
`ifdef ZAP_UART_TX_PARITY_EN
  localparam int FRAME_A = 176, FRAME_B = 22, NBITS = 11;
  localparam logic P03 = 1'b0;
  logic [10:0] line_41 = 11'b100_1000_0010;
  localparam logic PAR = 1'b1;
`else
  localparam int FRAME_A = 160, FRAME_B = 20, NBITS = 10;
  localparam logic P03 = 1'b1;
  logic [10:0] line_41 = 11'b110_1000_0010;
  localparam logic PAR = 1'b0;
`endif
  logic clk = 1'b0, rst_n;
  logic [7:0] data_a = '0, data_b = '0;
  logic valid_a = 1'b0, valid_b = 1'b0;
  logic ready_a, tx_a, busy_a, ready_b, tx_b, busy_b;
  logic [2:0] cnt_a, cnt_b;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  zap_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(data_a), .i_valid(valid_a),
    .o_ready(ready_a), .o_tx(tx_a), .o_busy(busy_a), .o_fifo_count(cnt_a));
  zap_uart_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(data_b), .i_valid(valid_b),
    .o_ready(ready_b), .o_tx(tx_b), .o_busy(busy_b), .o_fifo_count(cnt_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // frame-level model: queue of accepted bytes plus the bit pattern of the frame on the line
  logic [7:0] q[$], dec_exp[$];
  logic [10:0] fb = '1;
  bit act = 1'b0, m_push;
  int pos = 0;
  logic m_tx = 1'b1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      dec_exp.delete();
      act = 1'b0;
      pos = 0;
      m_tx = 1'b1;
    end else begin
      m_push = valid_a && q.size() != DEPTH;
      if (act && pos != NBITS * CPB - 1) pos++;
      else if (q.size() != 0) begin
        fb = {1'b1, PAR ? ^q[0] : 1'b1, q[0], 1'b0};
        void'(q.pop_front());
        act = 1'b1;
        pos = 0;
      end else act = 1'b0;
      if (m_push) begin
        q.push_back(data_a);
        dec_exp.push_back(data_a);
      end
      m_tx = act ? fb[pos / CPB] : 1'b1;
    end

  always @(negedge clk) begin
    n_tests++;
    if (tx_a !== m_tx || busy_a !== (act || q.size() != 0) || ready_a !== (q.size() != DEPTH) ||
        cnt_a !== 3'(q.size())) begin
      n_fail++;
      $display("FAIL model at %0t: tx=%b busy=%b ready=%b count=%0d, expected tx=%b busy=%b ready=%b count=%0d",
               $time, tx_a, busy_a, ready_a, cnt_a, m_tx, act || q.size() != 0, q.size() != DEPTH, q.size());
    end
  end

  // independent 16x oversampling decoder sampling mid-bit
  logic [7:0] rx = '0, last_rx = '0;
  bit dec_en = 1'b0;
  initial forever begin
    @(negedge tx_a);
    if (dec_en) begin
      repeat (CPB / 2) @(posedge clk);
      #1 check("rx_start", tx_a, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1 rx[i] = tx_a;
      end
`ifdef ZAP_UART_TX_PARITY_EN
      repeat (CPB) @(posedge clk);
      #1 check("rx_parity", tx_a, ^rx);
`endif
      repeat (CPB) @(posedge clk);
      #1 check("rx_stop", tx_a, 1);
      check("rx_expected_pending", dec_exp.size() != 0, 1);
      if (dec_exp.size() != 0) check("rx_byte", rx, dec_exp.pop_front());
      last_rx = rx;
    end
  end

  task automatic push_a(input logic [7:0] d);
    bit ok = 1'b0;
    valid_a = 1'b1;
    data_a = d;
    for (int i = 0; i < 4 * FRAME_A && !ok; i++) begin
      ok = ready_a;
      @(posedge clk);
      #1;
    end
    valid_a = 1'b0;
    check("push_accepted", ok, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 8 * FRAME_A && busy_a; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain", busy_a, 0);
  endtask

  task automatic probe_a(input logic [7:0] d, input int kc, input logic vc);
    wait_idle();
    valid_a = 1'b1;
    data_a = d;
    @(posedge clk);
    #1 valid_a = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k <= FRAME_A; k++) begin
      if (k == 0) check("probe_start", tx_a, 0);
      if (k == kc) check("probe_tx", tx_a, vc);
      if (k == FRAME_A - 1) check("probe_busy_end", busy_a, 1);
      if (k == FRAME_A) check("probe_idle", busy_a, 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int p;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx_a, 1);
    check("rst_ready", ready_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_count", cnt_a, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 dec_en = 1'b1;
    // single byte 'A': exact line shape and end of frame
    valid_a = 1'b1;
    data_a = 8'h41;
    @(posedge clk);
    #1 valid_a = 1'b0;
    check("pre_e1_tx", tx_a, 1);
    @(posedge clk);
    #1;
    for (int k = 0; k <= FRAME_A; k++) begin
      if (k < FRAME_A) check("a41_line", tx_a, line_41[k / CPB]);
      if (k == FRAME_A - 1) check("a41_busy_end", busy_a, 1);
      if (k == FRAME_A) check("a41_idle", busy_a, 0);
      @(posedge clk);
      #1;
    end
    check("rx_A", last_rx, 8'h41);
    // five-byte burst, sixth held until a pop
    for (int i = 0; i < 5; i++) begin
      check("burst_ready", ready_a, 1);
      valid_a = 1'b1;
      data_a = 8'(8'h10 + i);
      @(posedge clk);
      #1;
    end
    valid_a = 1'b0;
    check("burst_count", cnt_a, 4);
    check("burst_full_ready", ready_a, 0);
    push_a(8'h15);
    valid_a = 1'b1;
    data_a = 8'hFF;
    repeat (FRAME_A / 2) begin
      @(posedge clk);
      #1 check("full_hold_count", cnt_a, 4);
    end
    valid_a = 1'b0;
    // simultaneous push and pop at count 2: count only drops on pop edges here
    for (int i = 0; i < 8 * FRAME_A && cnt_a != 2; i++) begin
      @(posedge clk);
      #1;
    end
    check("count_two", cnt_a, 2);
    repeat (FRAME_A - 1) @(posedge clk);
    #1 check("pp_before", cnt_a, 2);
    valid_a = 1'b1;
    data_a = 8'h5A;
    @(posedge clk);
    #1 valid_a = 1'b0;
    check("pp_after", cnt_a, 2);
    // randomized traffic with varying density
    for (int b = 0; b < 6; b++) begin
      p = $urandom_range(0, 25);
      repeat (500) begin
        valid_a = $urandom_range(0, 999) < p;
        data_a = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    valid_a = 1'b0;
    wait_idle();
    check("rx_all_decoded", dec_exp.size(), 0);
    dec_en = 1'b0;
    // reset during data bit 3 of 8'h55 with two bytes queued
    push_a(8'h55);
    push_a(8'hAA);
    push_a(8'h33);
    repeat (69) @(posedge clk);
    #1 check("pre_rst_tx", tx_a, 0);
    check("pre_rst_count", cnt_a, 2);
    valid_a = 1'b1;
    data_a = 8'h77;
    #2 rst_n = 1'b0;
    #1 check("async_rst_tx", tx_a, 1);
    check("async_rst_count", cnt_a, 0);
    check("async_rst_busy", busy_a, 0);
    check("async_rst_ready", ready_a, 1);
    repeat (3) @(posedge clk);
    #1 valid_a = 1'b0;
    check("rst_valid_ignored", cnt_a, 0);
    #1 rst_n = 1'b1;
    repeat (50) begin
      @(posedge clk);
      #1 check("post_rst_quiet", {tx_a, busy_a}, 2'b10);
    end
    push_a(8'hC3);
    wait_idle();
    // frame length and parity bit
    probe_a(8'h07, 9 * CPB + CPB / 2, 1'b1);
    probe_a(8'h03, 9 * CPB + CPB / 2, P03);
    // short bit time on the second instance
    valid_b = 1'b1;
    data_b = 8'h80;
    @(posedge clk);
    #1 valid_b = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k <= FRAME_B; k++) begin
      check("b80_tx", tx_b, (k >= 16) ? 1 : 0);
      check("b80_busy", busy_b, k < FRAME_B);
      @(posedge clk);
      #1;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/zap_uart_tx.md
Name: zap_uart_tx

Overview:
- Synthesizable 8N1 UART transmitter with a byte-wide valid/ready input and a small TX FIFO.
- Serializes bytes LSB-first onto a single line.
- Drives the serial input of the Wishbone UART or the bench's serial decoder, which samples at 16 clocks per bit.
- Test-harness serial source and reusable core TX path.

Parameters:
CLKS_PER_BIT, 16, clock cycles each serial bit is held; legal range is 2 or more.
FIFO_DEPTH, 4, byte entries in the TX FIFO; must be a power of 2 and at least 2.

Ports:
i_clk  input  1  clock
i_reset_n  input  1  asynchronous active-low reset
i_data  input  8  byte to transmit
i_valid  input  1  i_data valid
o_ready  output  1  FIFO can accept a byte
o_tx  output  1  serial line; idle high
o_busy  output  1  FIFO non-empty or frame in progress
o_fifo_count  output  $clog2(FIFO_DEPTH+1)  bytes queued, excluding the byte being shifted

Behaviour:
- Interface: one clock, i_clk. Reset i_reset_n is asynchronous and active-low.
- Reset values: o_tx=1, o_ready=1, o_busy=0, o_fifo_count=0, FSM=IDLE, FIFO pointers=0, bit and cycle counters=0.
- Push: occurs at the posedge where i_valid && o_ready.
- o_ready: equals (o_fifo_count != FIFO_DEPTH). It is combinational from the registered count.
- i_data: is don't-care when i_valid=0.
- Pop: the FSM pops the head byte when it is in IDLE, or in the final cycle of STOP, and the FIFO is non-empty.
- Simultaneous push and pop: o_fifo_count is unchanged. Read and write pointers both advance and wrap modulo FIFO_DEPTH.
- Push to a full FIFO: impossible, because o_ready=0. i_valid while full is ignored with no data loss to existing entries.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If the FIFO is non-empty, pop into an 8-bit shift register, then go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: o_tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. On the final cycle, go to START if the FIFO is non-empty (back-to-back frames, no idle gap), else go to IDLE.
- Latency: a byte pushed into an empty, idle block at edge E0 produces the o_tx falling edge at E1.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Cycle counter: counts 0..CLKS_PER_BIT-1 and wraps. Bit counter: counts 0..7.
- o_tx: driven from a flop, so it is glitch-free.
- o_busy: equals (FSM != IDLE) || (o_fifo_count != 0).
- Reset mid-frame: o_tx returns to 1 immediately (asynchronous), the FIFO is flushed, and the partial frame is abandoned. The first frame after release begins no earlier than one cycle after a push.
- i_valid asserted during reset: ignored.

Optional Feature:
- Macro: ZAP_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - o_tx carries the even parity bit, XOR of the 8 data bits, for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic. Frame is 8N1, 10*CLKS_PER_BIT cycles.

Test Plan:
1. Reset, then push 8'h41 with CLKS_PER_BIT=16 → o_tx is 1 before E1. From E1, o_tx shows:
   - 0 for 16 cycles (start bit);
   - 1,0,0,0,0,0,1,0 at 16 cycles each (LSB first);
   - 1 for 16 cycles (stop bit).
   Then o_busy=0 at cycle 160 after E1, and a 16x-oversampled decoder reports 'A'.
2. Push 5 bytes 8'h10..8'h14 in consecutive cycles with FIFO_DEPTH=4 → the first byte pops at E1, so all 5 are accepted. A sixth push is held with o_ready=0 until the next pop. The output is 5 contiguous 160-cycle frames with no idle gap between stop and start.
3. Hold i_valid=1 with 8'hFF while the FIFO is full → o_fifo_count stays 4 and queued contents are unchanged. Push and pop in the same cycle at count 2 → count stays 2.
4. Assert i_reset_n=0 during DATA bit 3 of 8'h55 with 2 bytes queued → o_tx=1 asynchronously, o_fifo_count=0, o_busy=0. After release, no frame starts until a new push.
5. With ZAP_UART_TX_PARITY_EN, push 8'h07 → parity bit is 1, frame is 176 cycles. Push 8'h03 → parity bit is 0. Without the macro, 8'h07 produces 160 cycles.
6. CLKS_PER_BIT=2, push 8'h80 → start bit is 2 cycles and data bit 7 is high for the 2 cycles before stop. Total frame is 20 cycles.
